rf_writeback: RTL and testbench
===============================

Name: rf_writeback

Overview:
- Write-side initiator for the core's 32x32 register file.
- Merges completed results from two producers into the single register-file write port:
  - the single-cycle ALU result path;
  - the load-return path from the LSU.
- Load data is aligned and sign/zero-extended by the block.
- ALU results that lose arbitration are buffered in a small FIFO.
- A pending-register mask is exported so issue logic can stall reads and writes to registers whose write has not yet landed.

Parameters:
- FIFO_DEPTH, 2, number of buffered ALU results; power of 2, ≥2.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high reset
- alu_valid  in  1  ALU result offered
- alu_ready  out  1  block accepts ALU result this cycle
- alu_rd  in  5  ALU destination register
- alu_data  in  32  ALU result
- ld_valid  in  1  load data returning; always accepted, no backpressure
- ld_rd  in  5  load destination register
- ld_funct3  in  3  load type: LB=000, LH=001, LW=010, LBU=100, LHU=101
- ld_addr_lo  in  2  load address bits [1:0]
- ld_rdata  in  32  raw aligned memory word
- rf_we  out  1  register-file write enable (registered)
- rf_wa  out  5  register-file write address (registered)
- rf_wdata  out  32  register-file write data (registered)
- pend_mask  out  32  bit r=1 while a write to xr is buffered or on rf_*
- ld_err  out  1  one-cycle pulse: illegal ld_funct3 received

Behaviour:
- Reset, while reset=1 at a rising edge:
  - FIFO count=0 and contents discarded.
  - rf_we=0, rf_wa=0, rf_wdata=0, ld_err=0.
  - pend_mask therefore reads 0 the cycle after.
  - alu_ready=0 combinationally while reset=1; alu and ld inputs are ignored.
  - Reset mid-operation drops all buffered and in-flight writes; no write is issued in the reset cycle or after it.
- Handshake:
  - alu_ready = !reset && count<FIFO_DEPTH, computed from registered count only.
  - An ALU transfer occurs when alu_valid && alu_ready at a clock edge.
  - When full, no enqueue happens even if a drain occurs in the same cycle.
- rd=0 handling:
  - An ALU transfer with alu_rd=0 is accepted but not enqueued.
  - A load with ld_rd=0 produces no write.
  - rf_we is never 1 with rf_wa=0.
- Arbitration per cycle, exactly one source for the next rf_* registers:
  - If ld_valid with a legal funct3 and ld_rd≠0: the load is written. The FIFO holds.
  - Else if count>0: the FIFO head is written and popped.
  - Else if an ALU transfer with rd≠0 occurs while count=0: it bypasses the FIFO and is written directly. It is not enqueued.
  - Else rf_we=0 next cycle. rf_wa and rf_wdata hold their previous values.
- Ordering and latency:
  - The FIFO drains strictly in arrival order.
  - Enqueue and pop in the same cycle are allowed when not full.
  - Latency is 1 cycle from acceptance to rf_we=1 when there is no contention.
  - A buffered ALU result waits while ld_valid stays high; there is no starvation limit, and the LSU duty cycle is bounded upstream.
- Load extraction, with shift = ld_addr_lo*8:
  - LB: ld_rdata[shift+7:shift], sign-extended to 32 bits.
  - LBU: the same byte, zero-extended.
  - LH: ld_rdata[ld_addr_lo[1]*16+15 : ld_addr_lo[1]*16], sign-extended; ld_addr_lo[0] is ignored.
  - LHU: the same halfword, zero-extended.
  - LW: ld_rdata unchanged; ld_addr_lo is ignored.
- Illegal funct3 (011, 110, 111):
  - No write is issued.
  - ld_err=1 on the next cycle for one cycle.
  - The FIFO may drain in that cycle as if ld_valid=0.
- pend_mask:
  - Combinational from registered state.
  - Bit r = (any valid FIFO entry has rd=r) OR (rf_we && rf_wa=r).
  - Bit 0 is always 0.
  - A newly accepted ALU or load rd appears in the mask the cycle after acceptance.
- Issue-side guarantee: issue logic never presents two outstanding writes to the same rd, enforced via pend_mask. WAW between sources is therefore excluded and not checked.

Test Plan:
- Reset, then a single ALU transfer (rd=5, data=0x1234_5678) with count=0 -> next cycle rf_we=1, rf_wa=5, rf_wdata=0x12345678, pend_mask=0x20; the following cycle rf_we=0 and pend_mask=0.
- Loads with ld_rdata=0x80F1_7F82:
  - LB, addr_lo=0 -> 0xFFFFFF82
  - LBU, addr_lo=0 -> 0x00000082
  - LB, addr_lo=1 -> 0x0000007F
  - LH, addr_lo=2 -> 0xFFFF80F1
  - LHU, addr_lo=2 -> 0x000080F1
  - LW -> 0x80F17F82
- ld_valid held 4 cycles (rd=1..4) while ALU offers rd=10, 11, 12 -> rd 10 and 11 enqueued, alu_ready=0 at count=2, rd 12 stalls; writes issued in order 1, 2, 3, 4, 10, 11, 12; pend_mask shows bits 10 and 11 while they are buffered.
- ALU rd=0 and load rd=0 -> both accepted, rf_we stays 0, pend_mask stays 0.
- ld_funct3=011 -> no write; ld_err pulses exactly one cycle.
- reset asserted with count=2 and rf_we=1 -> the next cycle rf_we=0, pend_mask=0, and the discarded entries are never written after reset is released.

Source files
------------

// File: rtl/rf_writeback.sv
// Register-file write-port initiator: merges load returns and ALU results into one
// registered write, buffering ALU results that lose to a load in a small FIFO.
module rf_writeback #(
  parameter int FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        alu_valid,
  output logic        alu_ready,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  input  logic        ld_valid,
  input  logic [4:0]  ld_rd,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_addr_lo,
  input  logic [31:0] ld_rdata,
  output logic        rf_we,
  output logic [4:0]  rf_wa,
  output logic [31:0] rf_wdata,
  output logic [31:0] pend_mask,
  output logic        ld_err
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  logic [4:0]    fifo_rd   [FIFO_DEPTH];
  logic [31:0]   fifo_data [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;

  logic        alu_xfer;
  logic        ld_legal;
  logic        ld_wr;
  logic        pop;
  logic        bypass;
  logic        enq;
  logic [31:0] ld_ext;

  // ALU handshake: a result transfers on a rising edge where alu_valid && alu_ready.
  // alu_ready depends only on registered count (and reset), never on alu_valid.
  assign alu_ready = !reset && (count < CW'(FIFO_DEPTH));
  assign alu_xfer  = alu_valid && alu_ready;

  always_comb begin
    ld_legal = 1'b0;
    case (ld_funct3)
      3'b000, 3'b001, 3'b010, 3'b100, 3'b101: ld_legal = 1'b1;
      default: ld_legal = 1'b0;
    endcase
  end

  // Priority: legal load, then FIFO head, then same-cycle ALU bypass when empty.
  assign ld_wr  = ld_valid && ld_legal && (ld_rd != 5'd0);
  assign pop    = !ld_wr && (count != '0);
  assign bypass = !ld_wr && (count == '0) && alu_xfer && (alu_rd != 5'd0);
  assign enq    = alu_xfer && (alu_rd != 5'd0) && !bypass;

  always_comb begin
    logic [4:0]  shift;
    logic [7:0]  b;
    logic [15:0] h;
    shift = {ld_addr_lo, 3'b000};
    b     = ld_rdata[shift +: 8];
    h     = ld_addr_lo[1] ? ld_rdata[31:16] : ld_rdata[15:0];
    case (ld_funct3)
      3'b000:  ld_ext = {{24{b[7]}}, b};
      3'b100:  ld_ext = {24'b0, b};
      3'b001:  ld_ext = {{16{h[15]}}, h};
      3'b101:  ld_ext = {16'b0, h};
      default: ld_ext = ld_rdata;
    endcase
  end

  // Storage needs no reset: entries are only visible below count.
  always_ff @(posedge clk) begin
    if (!reset && enq) begin
      fifo_rd[wr_ptr]   <= alu_rd;
      fifo_data[wr_ptr] <= alu_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      rf_we    <= 1'b0;
      rf_wa    <= 5'd0;
      rf_wdata <= 32'd0;
      ld_err   <= 1'b0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count  <= count + CW'(enq) - CW'(pop);
      ld_err <= ld_valid && !ld_legal;
      rf_we  <= ld_wr || pop || bypass;
      if (ld_wr) begin
        rf_wa    <= ld_rd;
        rf_wdata <= ld_ext;
      end else if (pop) begin
        rf_wa    <= fifo_rd[rd_ptr];
        rf_wdata <= fifo_data[rd_ptr];
      end else if (bypass) begin
        rf_wa    <= alu_rd;
        rf_wdata <= alu_data;
      end
    end
  end

  always_comb begin
    pend_mask = 32'd0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (CW'(i) < count) pend_mask[fifo_rd[rd_ptr + PW'(i)]] = 1'b1;
    end
    if (rf_we) pend_mask[rf_wa] = 1'b1;
    pend_mask[0] = 1'b0;
  end

endmodule

// File: tb/tb_rf_writeback.sv
// Bench for rf_writeback: directed scenarios with an expected-write queue checked
// against every rf_we pulse, plus cycle-level checks of ready, pend_mask and ld_err.
module tb_rf_writeback;

  logic        clk;
  logic        reset;
  logic        alu_valid;
  logic        alu_ready;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        ld_valid;
  logic [4:0]  ld_rd;
  logic [2:0]  ld_funct3;
  logic [1:0]  ld_addr_lo;
  logic [31:0] ld_rdata;
  logic        rf_we;
  logic [4:0]  rf_wa;
  logic [31:0] rf_wdata;
  logic [31:0] pend_mask;
  logic        ld_err;

  int checks   = 0;
  int failures = 0;
  logic [36:0] exp_q[$];

  rf_writeback #(.FIFO_DEPTH(2)) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_funct3(ld_funct3), .ld_addr_lo(ld_addr_lo),
    .ld_rdata(ld_rdata),
    .rf_we(rf_we), .rf_wa(rf_wa), .rf_wdata(rf_wdata), .pend_mask(pend_mask), .ld_err(ld_err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alu_valid  = 1'b0;
    alu_rd     = 5'd0;
    alu_data   = 32'd0;
    ld_valid   = 1'b0;
    ld_rd      = 5'd0;
    ld_funct3  = 3'b010;
    ld_addr_lo = 2'd0;
    ld_rdata   = 32'd0;
  endtask

  task automatic drive_alu(input logic [4:0] rd, input logic [31:0] data);
    alu_valid = 1'b1;
    alu_rd    = rd;
    alu_data  = data;
  endtask

  task automatic drive_ld(input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] lo,
                          input logic [31:0] data);
    ld_valid   = 1'b1;
    ld_rd      = rd;
    ld_funct3  = f3;
    ld_addr_lo = lo;
    ld_rdata   = data;
  endtask

  // scoreboard: every register-file write must match the head of exp_q
  always @(negedge clk) begin
    if (rf_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write_we", {31'b0, rf_we}, 32'd0);
      end else begin
        logic [36:0] e;
        e = exp_q.pop_front();
        check("write_wa", {27'b0, rf_wa}, {27'b0, e[36:32]});
        check("write_wdata", rf_wdata, e[31:0]);
      end
    end
  end

  logic [2:0]  ld_f3_t  [6] = '{3'b000, 3'b100, 3'b000, 3'b001, 3'b101, 3'b010};
  logic [1:0]  ld_lo_t  [6] = '{2'd0, 2'd0, 2'd1, 2'd2, 2'd2, 2'd3};
  logic [31:0] ld_exp_t [6] = '{32'hFFFFFF82, 32'h00000082, 32'h0000007F,
                                32'hFFFF80F1, 32'h000080F1, 32'h80F17F82};
  logic        rdy_t  [8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
  logic [31:0] pend_t [8] = '{32'h0, 32'h402, 32'hC04, 32'hC08, 32'hC10,
                              32'hC00, 32'h1800, 32'h1000};

  initial begin
    logic [31:0] ld_words  [4];
    logic [31:0] alu_words [3];
    int          idx;
    logic        xfer;

    idle();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_rf_we", {31'b0, rf_we}, 32'd0);
    check("rst_rf_wa", {27'b0, rf_wa}, 32'd0);
    check("rst_rf_wdata", rf_wdata, 32'd0);
    check("rst_pend", pend_mask, 32'd0);
    check("rst_ld_err", {31'b0, ld_err}, 32'd0);
    check("rst_alu_ready", {31'b0, alu_ready}, 32'd0);
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("alu_ready_after_rst", {31'b0, alu_ready}, 32'd1);

    // single ALU bypass write
    tick();
    drive_alu(5'd5, 32'h12345678);
    exp_q.push_back({5'd5, 32'h12345678});
    tick();
    idle();
    @(negedge clk);
    check("bypass_we", {31'b0, rf_we}, 32'd1);
    check("bypass_pend", pend_mask, 32'h20);
    tick();
    @(negedge clk);
    check("bypass_we_clear", {31'b0, rf_we}, 32'd0);
    check("bypass_pend_clear", pend_mask, 32'd0);

    // load alignment / extension, back to back
    for (int i = 0; i < 6; i++) begin
      tick();
      drive_ld(5'(i + 1), ld_f3_t[i], ld_lo_t[i], 32'h80F17F82);
      exp_q.push_back({5'(i + 1), ld_exp_t[i]});
    end
    tick();
    idle();
    repeat (2) tick();

    // loads hold the port for 4 cycles while ALU offers rd 10, 11, 12
    for (int i = 0; i < 4; i++) ld_words[i] = $urandom;
    for (int i = 0; i < 3; i++) alu_words[i] = $urandom;
    for (int i = 0; i < 4; i++) exp_q.push_back({5'(i + 1), ld_words[i]});
    for (int i = 0; i < 3; i++) exp_q.push_back({5'(10 + i), alu_words[i]});
    idx  = 0;
    xfer = 1'b0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (xfer) idx++;
      idle();
      if (c < 4) drive_ld(5'(c + 1), 3'b010, 2'($urandom_range(0, 3)), ld_words[c]);
      if (idx < 3) drive_alu(5'(10 + idx), alu_words[idx]);
      @(negedge clk);
      check($sformatf("cont_ready_c%0d", c), {31'b0, alu_ready}, {31'b0, rdy_t[c]});
      check($sformatf("cont_pend_c%0d", c), pend_mask, pend_t[c]);
      xfer = alu_valid && alu_ready;
    end
    tick();
    idle();
    repeat (2) tick();

    // rd=0 from both sources: accepted, never written
    drive_alu(5'd0, 32'hDEADBEEF);
    drive_ld(5'd0, 3'b010, 2'd0, 32'hCAFEF00D);
    @(negedge clk);
    check("rd0_alu_ready", {31'b0, alu_ready}, 32'd1);
    tick();
    idle();
    @(negedge clk);
    check("rd0_we", {31'b0, rf_we}, 32'd0);
    check("rd0_pend", pend_mask, 32'd0);

    // illegal funct3
    tick();
    drive_ld(5'd7, 3'b011, 2'd0, 32'h11111111);
    tick();
    idle();
    @(negedge clk);
    check("illegal_err", {31'b0, ld_err}, 32'd1);
    check("illegal_we", {31'b0, rf_we}, 32'd0);
    check("illegal_pend", pend_mask, 32'd0);
    tick();
    @(negedge clk);
    check("illegal_err_pulse", {31'b0, ld_err}, 32'd0);

    // reset with a full FIFO and a write on the port
    tick();
    drive_ld(5'd20, 3'b010, 2'd0, 32'hA0A0A0A0);
    drive_alu(5'd21, 32'hA1A1A1A1);
    exp_q.push_back({5'd20, 32'hA0A0A0A0});
    tick();
    drive_ld(5'd22, 3'b010, 2'd0, 32'hA2A2A2A2);
    drive_alu(5'd23, 32'hA3A3A3A3);
    exp_q.push_back({5'd22, 32'hA2A2A2A2});
    tick();
    idle();
    reset = 1'b1;
    @(negedge clk);
    check("pre_rst_pend", pend_mask, 32'h00E00000);
    tick();
    @(negedge clk);
    check("mid_rst_we", {31'b0, rf_we}, 32'd0);
    check("mid_rst_pend", pend_mask, 32'd0);
    check("mid_rst_ready", {31'b0, alu_ready}, 32'd0);
    tick();
    reset = 1'b0;
    repeat (6) tick();
    @(negedge clk);
    check("post_rst_pend", pend_mask, 32'd0);
    check("exp_q_drained", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
